serial_seq_gen: RTL and testbench
=================================

# serial_seq_gen

Serial bit-stream transmitter that feeds the pattern-detector FSMs. It accepts a parallel word through a valid/ready handshake and shifts it out MSB-first on a single serial line. After each word it drives a programmable idle gap. It is the driving end of the `in_seq` line and is the stimulus source for detector bring-up and for the self-checking testbenches.

## Interface
Parameters:
- `WIDTH`, default 8: data word width, range 2–32.
- `GAP`, default 1: idle cycles driven after the last data bit, range 0–15.
- `IDLE_BIT`, default 1'b1: line level while idle or in the gap. A high idle keeps a "01" detector parked in its reset state.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: **synchronous, active-high** reset. Sampled on the `clk` rising edge only.
- `load_valid`, input, 1: `load_data` is valid.
- `load_data`, input, WIDTH: word to transmit.
- `load_ready`, output, 1: block can accept a word.
- `seq_out`, output, 1: serial line, drives a detector `in_seq`.
- `busy`, output, 1: data or gap bits are being driven.
- `done`, output, 1: one-cycle pulse, asserted during the final data bit.
- `expect_y`, output, 1: reference "01" detection pulse. Active only with the macro.
- `expect_cnt`, output, 8: "01" detections in the current word. Active only with the macro.

## Operation
- FSM states:
  - IDLE: `load_ready`=1, `seq_out`=IDLE_BIT, `busy`=0.
  - SHIFT: drives data bits.
  - GAP: drives IDLE_BIT for GAP cycles.
- IDLE → SHIFT on the edge where `load_valid && load_ready`.
  - The word is captured into a WIDTH-bit shift register.
  - The bit counter is loaded with WIDTH-1.
- SHIFT:
  - `seq_out` = shift register MSB; the register shifts left by 1 per cycle.
  - The counter decrements each cycle.
  - `done`=1 when the counter is 0.
  - At counter 0: go to GAP if GAP>0, else to IDLE.
- GAP: the gap counter runs GAP cycles, then the FSM goes to IDLE.
- `load_valid` is ignored outside IDLE. `load_data` is sampled only on the accepting edge.
- Counter width is `$clog2(WIDTH)` for bits and 4 bits for the gap. There is no wrap: counters reload on entry to their state.
- Undefined state encodings go to IDLE on the next edge.
- Reset takes priority over everything, including mid-word.
  - On the next edge: state=IDLE, shift register cleared, `seq_out`=IDLE_BIT, `load_ready`=1, `busy`=0, `done`=0, `expect_y`=0, `expect_cnt`=0.
  - A word being transmitted is abandoned and not resumed.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Timing
- Accept on edge k. Data bit i (i=0 is the MSB) appears on `seq_out` in cycle k+1+i.
- `done` is high in cycle k+WIDTH.
- The gap occupies cycles k+WIDTH+1 … k+WIDTH+GAP.
- IDLE, with `load_ready`=1, is in cycle k+WIDTH+GAP+1.
- Minimum spacing between accepted words is WIDTH+GAP+1 cycles. An IDLE cycle always separates words.
- `busy`=1 exactly from cycle k+1 through k+WIDTH+GAP.
- `load_valid` held high continuously: words are accepted every WIDTH+GAP+1 cycles with none lost.

## Configuration
- Macro: `SERIAL_SEQ_GEN_EXPECT_EN`.
- When defined, a reference Moore "01" detector samples `seq_out` each edge.
  - The previous bit resets to IDLE_BIT.
  - `expect_y`=1 in the cycle after a cycle in which `seq_out`=1 and the previous-cycle `seq_out`=0.
  - `expect_cnt` clears to 0 on the accepting edge.
  - `expect_cnt` increments for each detection whose '1' bit is a data bit of the current word (gap and idle bits excluded).
  - `expect_cnt` saturates at 255 and holds its value until the next accept.
- When not defined:
  - `expect_y` and `expect_cnt` are tied to 0.
  - The ports remain present.
  - No detector logic is synthesized.

## Test plan
- Reset with `reset` held 3 cycles → `seq_out`=1, `load_ready`=1, `busy`=0, `done`=0, `expect_cnt`=0.
- WIDTH=8, GAP=1, load 8'hA5 →
  - `seq_out` = 1,0,1,0,0,1,0,1 on cycles k+1…k+8.
  - `done` is high only in cycle k+8.
  - `seq_out`=1 in the gap at k+9.
  - `load_ready`=1 at k+10.
  - With the macro: `expect_cnt`=3.
- Load 8'h55, then 8'hFF, with `load_valid` held high →
  - The second accept occurs exactly 10 cycles after the first.
  - With the macro: `expect_cnt`=4, then 0.
- Load 8'h00 with GAP=0 →
  - Eight 0 bits, then IDLE immediately after `done`.
  - With the macro: `expect_cnt`=0.
  - `expect_y` pulses once, 1 cycle after the first idle 1.
- Assert `reset` for 1 cycle during bit 4 of 8'hA5 →
  - Next cycle: `seq_out`=1, `busy`=0, `load_ready`=1.
  - No `done` pulse.
  - A new 8'h0F then transmits correctly.
- Drive `load_valid` pulses while `busy`=1 → ignored: `seq_out` is unchanged and no extra words are transmitted.

Source files
------------

// File: rtl/serial_seq_gen.sv
// MSB-first serial word transmitter with a valid/ready load port and a programmable idle gap.
// Define SERIAL_SEQ_GEN_EXPECT_EN to add a reference "01" detector on the serial line.
module serial_seq_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GAP      = 1,
  parameter logic        IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             seq_out,
  output logic             busy,
  output logic             done,
  output logic             expect_y,
  output logic [7:0]       expect_cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             seq_out_q, seq_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = load_data;
          bit_cnt_d = CNT_W'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == '0) begin
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(GAP - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    seq_out_d = (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : IDLE_BIT;
    busy_d    = (state_d == ST_SHIFT) || (state_d == ST_GAP);
    ready_d   = (state_d == ST_IDLE);
    done_d    = (state_d == ST_SHIFT) && (bit_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      seq_out_q <= IDLE_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      seq_out_q <= seq_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign seq_out    = seq_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = ready_q;

`ifdef SERIAL_SEQ_GEN_EXPECT_EN
  logic       prev_q, prev_d;
  logic       y_q, y_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hit_c;
  logic       accept_c;

  // A rising 0->1 on the line is a detection; only data bits of the current word are counted.
  assign hit_c    = seq_out_q & ~prev_q;
  assign accept_c = (state_q == ST_IDLE) && load_valid;

  always_comb begin
    prev_d = seq_out_q;
    y_d    = hit_c;
    cnt_d  = cnt_q;
    if (accept_c) begin
      cnt_d = '0;
    end else if (hit_c && (state_q == ST_SHIFT) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= IDLE_BIT;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  assign expect_y   = y_q;
  assign expect_cnt = cnt_q;
`else
  assign expect_y   = 1'b0;
  assign expect_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_seq_gen.sv
// Scoreboard bench for serial_seq_gen: one instance with GAP=1, one with GAP=0, checked every cycle.
module tb_serial_seq_gen;

`ifdef SERIAL_SEQ_GEN_EXPECT_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  typedef struct packed {
    logic seq;
    logic busy;
    logic done;
    logic ready;
    logic data;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] load_valid;
  logic [7:0] load_data [2];
  logic [1:0] load_ready, seq_out, busy, done, expect_y;
  logic [7:0] expect_cnt [2];

  always #5 clk = ~clk;

  serial_seq_gen #(.WIDTH(8), .GAP(1), .IDLE_BIT(1'b1)) u_dut_gap1 (
    .clk(clk), .reset(reset), .load_valid(load_valid[0]), .load_data(load_data[0]),
    .load_ready(load_ready[0]), .seq_out(seq_out[0]), .busy(busy[0]), .done(done[0]),
    .expect_y(expect_y[0]), .expect_cnt(expect_cnt[0])
  );

  serial_seq_gen #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b1)) u_dut_gap0 (
    .clk(clk), .reset(reset), .load_valid(load_valid[1]), .load_data(load_data[1]),
    .load_ready(load_ready[1]), .seq_out(seq_out[1]), .busy(busy[1]), .done(done[1]),
    .expect_y(expect_y[1]), .expect_cnt(expect_cnt[1])
  );

  beat_t      plan0 [$];
  beat_t      plan1 [$];
  beat_t      cur [2];
  logic       prev_m [2];
  logic       y_m [2];
  logic [7:0] cnt_m [2];
  bit         armed = 1'b0;
  int         n_checks = 0;
  int         n_fails = 0;
  int         y_pulses1 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t idle_beat();
    beat_t b;
    b = '{seq: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1, data: 1'b0};
    return b;
  endfunction

  // Expected line activity for one accepted word: 8 data bits MSB first, then the gap.
  task automatic push_word(input int u, input logic [7:0] d);
    beat_t b;
    int    gap;
    gap = (u == 0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      b = '{seq: d[7-i], busy: 1'b1, done: (i == 7), ready: 1'b0, data: 1'b1};
      if (u == 0) plan0.push_back(b); else plan1.push_back(b);
    end
    for (int g = 0; g < gap; g++) begin
      b = '{seq: 1'b1, busy: 1'b1, done: 1'b0, ready: 1'b0, data: 1'b0};
      if (u == 0) plan0.push_back(b); else plan1.push_back(b);
    end
  endtask

  task automatic model_step(input int u, input logic rst, input logic v);
    logic hit;
    logic accept;
    if (rst) begin
      if (u == 0) plan0.delete(); else plan1.delete();
      cur[u]    = idle_beat();
      prev_m[u] = 1'b1;
      y_m[u]    = 1'b0;
      cnt_m[u]  = 8'h00;
    end else begin
      hit    = cur[u].seq && !prev_m[u];
      accept = v && cur[u].ready;
      if (accept) cnt_m[u] = 8'h00;
      else if (hit && cur[u].data && cnt_m[u] != 8'hFF) cnt_m[u] = cnt_m[u] + 8'd1;
      y_m[u]    = hit;
      prev_m[u] = cur[u].seq;
      if (accept) push_word(u, load_data[u]);
      if (u == 0) begin
        if (plan0.size() > 0) cur[0] = plan0.pop_front(); else cur[0] = idle_beat();
      end else begin
        if (plan1.size() > 0) cur[1] = plan1.pop_front(); else cur[1] = idle_beat();
      end
    end
  endtask

  task automatic check_cycle(input int u);
    check_eq($sformatf("u%0d seq_out", u), 32'(seq_out[u]), 32'(cur[u].seq));
    check_eq($sformatf("u%0d busy", u), 32'(busy[u]), 32'(cur[u].busy));
    check_eq($sformatf("u%0d done", u), 32'(done[u]), 32'(cur[u].done));
    check_eq($sformatf("u%0d load_ready", u), 32'(load_ready[u]), 32'(cur[u].ready));
    check_eq($sformatf("u%0d expect_y", u), 32'(expect_y[u]), 32'(EXP_EN & y_m[u]));
    check_eq($sformatf("u%0d expect_cnt", u), 32'(expect_cnt[u]), EXP_EN ? 32'(cnt_m[u]) : 32'd0);
  endtask

  // One clock: check the current cycle, drive inputs for the next edge, advance the model.
  task automatic tick(input logic rst, input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    @(negedge clk);
    if (armed) begin
      check_cycle(0);
      check_cycle(1);
    end
    if (expect_y[1] === 1'b1) y_pulses1++;
    reset        = rst;
    load_valid   = {v1, v0};
    load_data[0] = d0;
    load_data[1] = d1;
    model_step(0, rst, v0);
    model_step(1, rst, v1);
    if (rst) armed = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    reset        = 1'b1;
    load_valid   = 2'b00;
    load_data[0] = 8'h00;
    load_data[1] = 8'h00;

    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(2);
    check_eq("reset seq_out", 32'(seq_out[0]), 32'd1);
    check_eq("reset expect_cnt", 32'(expect_cnt[0]), 32'd0);

    tick(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    idle(10);
    check_eq("A5 expect_cnt", 32'(expect_cnt[0]), EXP_EN ? 32'd3 : 32'd0);

    // 55 then FF with valid held high: the FF accept lands 10 cycles after the 55 accept.
    tick(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    repeat (9) tick(1'b0, 1'b1, 8'h55, 1'b0, 8'h00);
    check_eq("55 expect_cnt", 32'(expect_cnt[0]), EXP_EN ? 32'd4 : 32'd0);
    tick(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    idle(12);
    check_eq("FF expect_cnt", 32'(expect_cnt[0]), 32'd0);

    y_pulses1 = 0;
    tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    idle(12);
    check_eq("00 gap0 expect_cnt", 32'(expect_cnt[1]), 32'd0);
    check_eq("00 gap0 y pulses", 32'(y_pulses1), EXP_EN ? 32'd1 : 32'd0);

    // Reset in the middle of A5, then a clean 0F.
    tick(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
    idle(4);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(2);
    tick(1'b0, 1'b1, 8'h0F, 1'b0, 8'h00);
    idle(12);

    // Valid pulses while busy must be ignored.
    tick(1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3);
    for (int i = 0; i < 9; i++)
      tick(1'b0, 1'(i % 2), 8'($urandom), 1'(~i % 2), 8'($urandom));
    idle(12);

    // Back-to-back random words on both instances with valid held high.
    for (int i = 0; i < 40; i++)
      tick(1'b0, 1'b1, 8'($urandom), 1'b1, 8'($urandom));
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
